// File: rtl/mult_seq.sv
// Sequential 16x16 shift-add multiplier that borrows the execute-stage ALU for its ADD and SLL steps.
// Optional MULT_SEQ_EARLY_EXIT_EN stops iterating once the remaining multiplier bits are zero.
module mult_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   output logic             alu_cin,
   output logic             alu_inva,
   output logic             alu_invb,
   output logic             alu_sign,
   input  logic [WIDTH-1:0] alu_out,
   output logic [1:0]       dbg_state
);

   // Handshake: start is accepted only in IDLE (busy=0); done is a one-cycle
   // pulse in the DONE state and result is registered on the edge ending it.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADD   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b0010;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      alu_a    = '0;
      alu_b    = '0;
      alu_op   = ALU_ADD;
      done     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               prod_d   = '0;
               mcand_d  = op_a;
               mplier_d = op_b;
               cnt_d    = '0;
               state_d  = op_b[0] ? S_ADD : S_SHIFT;
`ifdef MULT_SEQ_EARLY_EXIT_EN
               if (op_b == '0) state_d = S_DONE;
`endif
            end
         end
         S_ADD: begin
            alu_a   = prod_q;
            alu_b   = mcand_q;
            alu_op  = ALU_ADD;
            prod_d  = alu_out;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            alu_a    = mcand_q;
            alu_b    = WIDTH'(1);
            alu_op   = ALU_SLL;
            mcand_d  = alu_out;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // mplier_q[1] becomes the next LSB after this shift
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = S_DONE;
`ifdef MULT_SEQ_EARLY_EXIT_EN
            end else if ((mplier_q >> 1) == '0) begin
               state_d = S_DONE;
`endif
            end else begin
               state_d = mplier_q[1] ? S_ADD : S_SHIFT;
            end
         end
         S_DONE: begin
            done     = 1'b1;
            result_d = prod_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign result    = result_q;
   assign alu_cin   = 1'b0;
   assign alu_inva  = 1'b0;
   assign alu_invb  = 1'b0;
   assign alu_sign  = 1'b0;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq with a behavioural ALU stand-in and a result/latency scoreboard.
module tb_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a, op_b;
  logic        busy, done;
  logic [15:0] result;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;
  logic        alu_cin, alu_inva, alu_invb, alu_sign;
  logic [1:0]  dbg_state;

  logic [15:0] exp_q[$];
  int          checks;
  int          errors;

  mult_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_inva(alu_inva), .alu_invb(alu_invb), .alu_sign(alu_sign),
    .alu_out(alu_out), .dbg_state(dbg_state)
  );

  // ALU subset used by the sequencer: ADD and SLL, modulo 2^16
  always_comb begin
    alu_out = 16'h0000;
    case (alu_op)
      4'b1000: alu_out = alu_a + alu_b;
      4'b0010: alu_out = alu_a << alu_b[3:0];
      default: alu_out = 16'h0000;
    endcase
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int latency(input logic [15:0] b);
    int pc;
    int msb;
    pc = 0;
    msb = -1;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) begin
        pc++;
        msb = i;
      end
    end
`ifdef MULT_SEQ_EARLY_EXIT_EN
    if (b == 16'h0000) return 1;
    return msb + 1 + pc + 1;
`else
    return 16 + pc + 1;
`endif
  endfunction

  function automatic logic [15:0] model_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0000, a} * {16'h0000, b};
    return p[15:0];
  endfunction

  // drive one start and push the expected product
  task automatic drive_start(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    exp_q.push_back(model_mul(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = 16'($urandom);
    op_b  = 16'($urandom);
  endtask

  // wait for done within a bound, check latency, then pop and compare result
  task automatic wait_done(input string tag, input int exp_lat);
    int cyc;
    bit got;
    logic [15:0] exp_r;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    exp_r = exp_q.pop_front();
    @(posedge clk);
    #1;
    check({tag, "_result"}, 32'(result), 32'(exp_r));
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_mult(input string tag, input logic [15:0] a, input logic [15:0] b);
    drive_start(a, b);
    wait_done(tag, latency(b));
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int cyc;
    int ndone;
    logic [15:0] ra, rb;
    checks = 0;
    errors = 0;
    start  = 1'b0;
    op_a   = 16'h0000;
    op_b   = 16'h0000;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'h8);
    check("rst_alu_ab", {alu_a, alu_b}, 32'd0);
    check("const_ctl", {28'd0, alu_cin, alu_inva, alu_invb, alu_sign}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_mult("t1_3x5", 16'd3, 16'd5);
    run_mult("t2_ffff", 16'hFFFF, 16'hFFFF);
    run_mult("t3_zero", 16'h1234, 16'h0000);
    run_mult("t6_msb", 16'h0003, 16'h8000);
    run_mult("t6_big", 16'h00FF, 16'h0101);

    // start pulses while busy (cycle 3 and the DONE cycle) must be ignored
    drive_start(16'd7, 16'd9);
    cyc = 0;
    ndone = 0;
    while (ndone == 0 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) begin
        start = 1'b1;
        op_a  = 16'd2;
        op_b  = 16'd2;
      end else if (cyc == 4) begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        start = 1'b1;
        op_a  = 16'd2;
        op_b  = 16'd2;
      end
    end
    check("t4_latency", 32'(cyc), 32'(latency(16'd9)));
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t4_result", 32'(result), 32'(exp_q.pop_front()));
    check("t4_idle", 32'(busy), 32'd0);
    expect_quiet("t4_no_extra_done", 40);

    // reset mid-operation aborts asynchronously
    @(negedge clk);
    op_a  = 16'd3;
    op_b  = 16'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_result", 32'(result), 32'd0);
    check("t5_rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_quiet("t5_no_done", 30);
    run_mult("t5_4x4", 16'd4, 16'd4);

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      run_mult("rand", ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
